// File: rtl/ternary_full_add.sv
// Registered unsigned ternary adder over binary-coded trits (00=0, 01=1, 10=2).
// NTRITS trits ripple combinationally from carry-in C; result lands one cycle after in_valid.
module ternary_full_add #(
  parameter int unsigned NTRITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [2*NTRITS-1:0]   A,
  input  logic [2*NTRITS-1:0]   B,
  input  logic [1:0]            C,
  output logic [2*NTRITS-1:0]   sum,
  output logic [1:0]            c_out,
  output logic                  out_valid,
  output logic                  err
);

  logic [2*NTRITS-1:0] sum_d;
  logic [1:0]          carry;
  logic                illegal;
  logic [1:0]          a_t;
  logic [1:0]          b_t;
  logic [2:0]          t;

  // Ripple chain; illegal trits may produce garbage here but the result is discarded.
  always_comb begin
    sum_d   = '0;
    carry   = C;
    illegal = C[1];
    a_t     = '0;
    b_t     = '0;
    t       = '0;
    for (int unsigned i = 0; i < NTRITS; i++) begin
      a_t     = A[2*i +: 2];
      b_t     = B[2*i +: 2];
      illegal = illegal | (&a_t) | (&b_t);
      t       = 3'(a_t) + 3'(b_t) + 3'(carry);
      if (t >= 3'd3) begin
        sum_d[2*i +: 2] = 2'(t - 3'd3);
        carry           = 2'b01;
      end else begin
        sum_d[2*i +: 2] = t[1:0];
        carry           = 2'b00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      c_out     <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      if (illegal) begin
        sum   <= '0;
        c_out <= '0;
        err   <= 1'b1;
      end else begin
        sum   <= sum_d;
        c_out <= carry;
        err   <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ternary_full_add.sv
// Directed bench for ternary_full_add: single-trit instance plus a two-trit ripple instance.
module tb_ternary_full_add;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid1 = 1'b0;
  logic [1:0] a1 = '0, b1 = '0, c1 = '0;
  logic [1:0] sum1, cout1;
  logic       ov1, err1;

  logic       in_valid2 = 1'b0;
  logic [3:0] a2 = '0, b2 = '0;
  logic [1:0] c2 = '0;
  logic [3:0] sum2;
  logic [1:0] cout2;
  logic       ov2, err2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ternary_full_add #(.NTRITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .A(a1), .B(b1), .C(c1),
    .sum(sum1), .c_out(cout1), .out_valid(ov1), .err(err1)
  );

  ternary_full_add #(.NTRITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .A(a2), .B(b2), .C(c2),
    .sum(sum2), .c_out(cout2), .out_valid(ov2), .err(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({sum1, cout1, ov1, err1} !== 6'b0) begin
      failures++; $display("FAIL reset_initial got=%b exp=%b", {sum1, cout1, ov1, err1}, 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 2'd2; b1 = 2'd2; c1 = 2'd1; in_valid1 = 1'b1;
    tick();
    checks++; if ({sum1, cout1, ov1, err1} !== 6'b10_01_1_0) begin
      failures++; $display("FAIL reset_preload got=%b exp=%b", {sum1, cout1, ov1, err1}, 6'b10_01_1_0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({sum1, cout1, ov1, err1} !== 6'b0) begin
      failures++; $display("FAIL reset_async got=%b exp=%b", {sum1, cout1, ov1, err1}, 6'b0);
    end
    in_valid1 = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    checks++; if ({sum1, cout1, ov1, err1} !== 6'b0) begin
      failures++; $display("FAIL reset_hold_after got=%b exp=%b", {sum1, cout1, ov1, err1}, 6'b0);
    end
  endtask

  // All 18 legal combinations back to back; expected from s = t mod 3, k = t div 3.
  task automatic test_sweep();
    int t;
    logic [1:0] es, ec;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 2; c++) begin
          a1 = 2'(a); b1 = 2'(b); c1 = 2'(c); in_valid1 = 1'b1;
          tick();
          t  = a + b + c;
          es = 2'(t % 3);
          ec = 2'(t / 3);
          checks++; if ({sum1, cout1, ov1, err1} !== {es, ec, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sweep a=%0d b=%0d c=%0d got=%b exp=%b", a, b, c,
                     {sum1, cout1, ov1, err1}, {es, ec, 1'b1, 1'b0});
          end
        end
  endtask

  task automatic test_table();
    logic [5:0] vec [6];
    logic [3:0] exp [6];
    vec[0] = {2'd0, 2'd0, 2'd0}; exp[0] = 4'b00_00;
    vec[1] = {2'd1, 2'd1, 2'd0}; exp[1] = 4'b10_00;
    vec[2] = {2'd1, 2'd1, 2'd1}; exp[2] = 4'b00_01;
    vec[3] = {2'd2, 2'd1, 2'd0}; exp[3] = 4'b00_01;
    vec[4] = {2'd2, 2'd2, 2'd0}; exp[4] = 4'b01_01;
    vec[5] = {2'd2, 2'd2, 2'd1}; exp[5] = 4'b10_01;
    for (int i = 0; i < 6; i++) begin
      {a1, b1, c1} = vec[i]; in_valid1 = 1'b1;
      tick();
      checks++; if ({sum1, cout1} !== exp[i]) begin
        failures++; $display("FAIL table_%0d got=%b exp=%b", i, {sum1, cout1}, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    a1 = 2'b11; b1 = 2'b00; c1 = 2'b00; in_valid1 = 1'b1;
    tick();
    checks++; if ({sum1, cout1, ov1, err1} !== 6'b00_00_1_1) begin
      failures++; $display("FAIL illegal_a got=%b exp=%b", {sum1, cout1, ov1, err1}, 6'b00_00_1_1);
    end
    a1 = 2'b01; b1 = 2'b01; c1 = 2'b00;
    tick();
    checks++; if ({sum1, cout1, ov1, err1} !== 6'b10_00_1_0) begin
      failures++; $display("FAIL illegal_clear got=%b exp=%b", {sum1, cout1, ov1, err1}, 6'b10_00_1_0);
    end
    a1 = 2'b00; b1 = 2'b00; c1 = 2'b10;
    tick();
    checks++; if ({sum1, cout1, ov1, err1} !== 6'b00_00_1_1) begin
      failures++; $display("FAIL illegal_c10 got=%b exp=%b", {sum1, cout1, ov1, err1}, 6'b00_00_1_1);
    end
    a1 = 2'b10; b1 = 2'b11; c1 = 2'b00;
    tick();
    checks++; if ({sum1, cout1, ov1, err1} !== 6'b00_00_1_1) begin
      failures++; $display("FAIL illegal_b got=%b exp=%b", {sum1, cout1, ov1, err1}, 6'b00_00_1_1);
    end
    a1 = 2'b10; b1 = 2'b10; c1 = 2'b11;
    tick();
    checks++; if ({sum1, cout1, ov1, err1} !== 6'b00_00_1_1) begin
      failures++; $display("FAIL illegal_c11 got=%b exp=%b", {sum1, cout1, ov1, err1}, 6'b00_00_1_1);
    end
    // err must hold through idle cycles as well
    in_valid1 = 1'b0; a1 = 2'b00; b1 = 2'b00; c1 = 2'b00;
    tick();
    checks++; if ({err1, ov1} !== 2'b10) begin
      failures++; $display("FAIL illegal_err_hold got=%b exp=%b", {err1, ov1}, 2'b10);
    end
  endtask

  task automatic test_hold();
    a1 = 2'd2; b1 = 2'd2; c1 = 2'd1; in_valid1 = 1'b1;
    tick();
    checks++; if ({sum1, cout1, ov1} !== 5'b10_01_1) begin
      failures++; $display("FAIL hold_load got=%b exp=%b", {sum1, cout1, ov1}, 5'b10_01_1);
    end
    in_valid1 = 1'b0; a1 = 2'd0; b1 = 2'd0; c1 = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({sum1, cout1, ov1, err1} !== 6'b10_01_0_0) begin
        failures++; $display("FAIL hold_cycle%0d got=%b exp=%b", i, {sum1, cout1, ov1, err1}, 6'b10_01_0_0);
      end
    end
  endtask

  // Two-trit expectations worked by hand: value = 3*trit1 + trit0.
  task automatic test_ripple();
    logic [9:0] vec [4];
    logic [7:0] exp [4];
    vec[0] = {4'b1010, 4'b0001, 2'd1}; exp[0] = {4'b0001, 2'b01, 2'b10}; // 8+1+1=10
    vec[1] = {4'b0110, 4'b0100, 2'd0}; exp[1] = {4'b1010, 2'b00, 2'b10}; // 5+3+0=8
    vec[2] = {4'b1010, 4'b1010, 2'd1}; exp[2] = {4'b1010, 2'b01, 2'b10}; // 8+8+1=17
    vec[3] = {4'b1100, 4'b0000, 2'd0}; exp[3] = {4'b0000, 2'b00, 2'b11}; // illegal upper trit
    for (int i = 0; i < 4; i++) begin
      {a2, b2, c2} = vec[i]; in_valid2 = 1'b1;
      tick();
      checks++; if ({sum2, cout2, ov2, err2} !== exp[i]) begin
        failures++; $display("FAIL ripple_%0d got=%b exp=%b", i, {sum2, cout2, ov2, err2}, exp[i]);
      end
    end
    in_valid2 = 1'b0;
    tick();
    checks++; if ({sum2, cout2, ov2, err2} !== 8'b0000_00_0_1) begin
      failures++; $display("FAIL ripple_idle got=%b exp=%b", {sum2, cout2, ov2, err2}, 8'b0000_00_0_1);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_table();
    test_illegal();
    test_hold();
    test_ripple();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
